// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// dcache_if : MEM-stage request and external memory bus bundle for dcache_ctrl
// Revision  : 1.0
// ============================================================================
interface dcache_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        waiting;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The cache controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wstrb, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, waiting, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // The pipeline plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wstrb, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, waiting, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_ctrl : direct-mapped, write-through, no-write-allocate data cache
// Revision    : 1.0
// ============================================================================
module dcache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 32 - INDEX_W - 4
) (
  input  logic    clk,
  input  logic    rst,
  dcache_if.slave bus
);
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_WDONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         cnt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*4];

  logic [31:2]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [3:0]         lat_wstrb;

  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W+1:0] cpu_sel;
  logic [INDEX_W-1:0] lat_index;
  logic               hit;
  logic               store_hit;
  logic               unused_ok;

  assign cpu_index = bus.cpu_addr[3+INDEX_W:4];
  assign cpu_tag   = bus.cpu_addr[31:4+INDEX_W];
  assign cpu_sel   = {cpu_index, bus.cpu_addr[3:2]};
  assign lat_index = lat_addr[3+INDEX_W:4];
  assign unused_ok = &{1'b0, bus.cpu_addr[1:0]};

  assign hit       = valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign store_hit = (state == ST_IDLE) && bus.cpu_req && bus.cpu_we && hit;

  // Zero-latency read path; reads as zero whenever the access misses
  assign bus.cpu_rdata = hit ? data_mem[cpu_sel] : 32'h0;

  assign bus.waiting = (state == ST_REFILL) || (state == ST_WRITE) ||
                       ((state == ST_IDLE) && bus.cpu_req && (bus.cpu_we || !hit));

  assign bus.mem_req = (state == ST_REFILL) || (state == ST_WRITE);
  assign bus.mem_we  = (state == ST_WRITE);

  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    case (state)
      ST_REFILL: bus.mem_addr = {lat_addr[31:4], cnt, 2'b00};
      ST_WRITE: begin
        bus.mem_addr  = {lat_addr, 2'b00};
        bus.mem_wdata = lat_wdata;
        bus.mem_wstrb = lat_wstrb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      valid     <= '0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      lat_wstrb <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              lat_addr  <= bus.cpu_addr[31:2];
              lat_wdata <= bus.cpu_wdata;
              lat_wstrb <= bus.cpu_wstrb;
              state     <= ST_WRITE;
            end else if (!hit) begin
              lat_addr <= bus.cpu_addr[31:2];
              cnt      <= 2'd0;
              state    <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 2'd1;
            // Line only becomes visible once every word has landed
            if (cnt == 2'd3) begin
              valid[lat_index] <= 1'b1;
              state            <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) state <= ST_WRITE + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; valid gates every use
  always_ff @(posedge clk) begin
    if ((state == ST_REFILL) && bus.mem_ack) begin
      data_mem[{lat_index, cnt}] <= bus.mem_rdata;
      if (cnt == 2'd3) tag_mem[lat_index] <= lat_addr[31:4+INDEX_W];
    end else if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_wstrb[b]) data_mem[cpu_sel][8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dcache_ctrl : scoreboard bench for dcache_ctrl with a latency-controlled memory
// Revision       : 1.0
// ============================================================================
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_if bus();
  dcache_ctrl #(.INDEX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] mem_model [bit [31:0]];
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Drives one access from a negedge and returns at the negedge after the pipeline advances
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input int lat, input string name,
                            output logic [31:0] rdata_out);
    int   idx;
    int   exp_wait;
    int   wait_cyc;
    int   hold;
    bit   done;
    txn_t t;
    logic [31:0] cur;
    logic [31:0] want;
    idx = int'(addr[7:4]);
    rdata_out = 32'h0;
    if (we) begin
      t.we = 1'b1; t.addr = {addr[31:2], 2'b00}; t.wdata = wdata; t.wstrb = strb;
      exp_txn.push_back(t);
      exp_wait = 1 + (lat + 1);
    end else if (m_valid[idx] && m_tag[idx] == addr[31:8]) begin
      exp_rdata.push_back(mem_rd(addr));
      exp_wait = 0;
    end else begin
      for (int w = 0; w < 4; w++) begin
        t.we = 1'b0; t.addr = {addr[31:4], w[1:0], 2'b00}; t.wdata = 32'h0; t.wstrb = 4'h0;
        exp_txn.push_back(t);
      end
      exp_rdata.push_back(mem_rd(addr));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[31:8];
      exp_wait = 1 + 4 * (lat + 1);
    end

    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wstrb = strb; bus.cpu_wdata = wdata;
    wait_cyc = 0; hold = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (bus.mem_req) begin
        n_checks++;
        if (exp_txn.size() == 0) begin
          $display("FAIL %s unexpected mem txn: got we=%b addr=%h, want none", name, bus.mem_we, bus.mem_addr);
        end else begin
          t = exp_txn[0];
          if (bus.mem_we !== t.we || bus.mem_addr !== t.addr || bus.mem_wstrb !== t.wstrb ||
              (t.we && bus.mem_wdata !== t.wdata))
            $display("FAIL %s mem txn: got we=%b addr=%h wstrb=%h wdata=%h, want we=%b addr=%h wstrb=%h wdata=%h",
                     name, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata,
                     t.we, t.addr, t.wstrb, t.wdata);
          else
            n_pass++;
        end
        if (hold == lat) begin
          bus.mem_ack = 1'b1;
          if (exp_txn.size() > 0) begin
            t = exp_txn.pop_front();
            bus.mem_rdata = mem_rd(t.addr);
            if (t.we) begin
              cur = mem_rd(t.addr);
              for (int b = 0; b < 4; b++) if (t.wstrb[b]) cur[8*b +: 8] = t.wdata[8*b +: 8];
              mem_model[t.addr] = cur;
            end
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
          end
          hold = 0;
        end else begin
          hold++;
        end
      end
      if (bus.waiting) begin
        wait_cyc++;
      end else begin
        done = 1'b1;
        if (!we) begin
          want = exp_rdata.pop_front();
          rdata_out = bus.cpu_rdata;
          n_checks++;
          if (bus.cpu_rdata !== want)
            $display("FAIL %s rdata: got %h, want %h", name, bus.cpu_rdata, want);
          else
            n_pass++;
        end
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!done)
      $display("FAIL %s timeout: waiting still high after 300 cycles, want release", name);
    else if (wait_cyc !== exp_wait)
      $display("FAIL %s waiting cycles: got %0d, want %0d", name, wait_cyc, exp_wait);
    else
      n_pass++;
    n_checks++;
    if (exp_txn.size() != 0) begin
      $display("FAIL %s outstanding mem txns: got %0d left, want 0", name, exp_txn.size());
      exp_txn.delete();
    end else begin
      n_pass++;
    end
  endtask

  task automatic go_idle(input int cycles);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.waiting, bus.mem_req, bus.mem_we} !== 3'b000)
      $display("FAIL reset ctrl: got waiting/req/we=%b, want 000", {bus.waiting, bus.mem_req, bus.mem_we});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0)
      $display("FAIL reset mem bus: got addr=%h wdata=%h wstrb=%h, want zeros",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    bus.cpu_addr = 32'h100;
    #1;
    n_checks++;
    if (bus.cpu_rdata !== 32'h0)
      $display("FAIL reset rdata: got %h, want 00000000", bus.cpu_rdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_miss();
    logic [31:0] r;
    run_access(1'b0, 32'h100, 4'h0, 32'h0, 0, "load_miss_100", r);
    n_checks++;
    if (r !== 32'h11) $display("FAIL load_miss_100 value: got %h, want 00000011", r);
    else n_pass++;
  endtask

  task automatic test_load_hit();
    logic [31:0] r;
    run_access(1'b0, 32'h10C, 4'h0, 32'h0, 0, "load_hit_10c", r);
    n_checks++;
    if (r !== 32'h44) $display("FAIL load_hit_10c value: got %h, want 00000044", r);
    else n_pass++;
  endtask

  task automatic test_store_hit();
    logic [31:0] r;
    run_access(1'b1, 32'h108, 4'b0011, 32'hAAAA5555, 1, "store_hit_108", r);
    run_access(1'b0, 32'h108, 4'h0, 32'h0, 0, "load_after_store_108", r);
    n_checks++;
    if (r !== 32'h00005555) $display("FAIL store_merge value: got %h, want 00005555", r);
    else n_pass++;
  endtask

  task automatic test_conflict();
    logic [31:0] r;
    run_access(1'b0, 32'h500, 4'h0, 32'h0, 2, "load_conflict_500", r);
    run_access(1'b0, 32'h100, 4'h0, 32'h0, 0, "reload_100", r);
  endtask

  task automatic test_store_miss();
    logic [31:0] r;
    run_access(1'b1, 32'h2000, 4'hF, 32'hCAFEF00D, 3, "store_miss_2000", r);
    run_access(1'b0, 32'h100, 4'h0, 32'h0, 1, "line_intact_100", r);
    n_checks++;
    if (r !== 32'h11) $display("FAIL store_miss untouched: got %h, want 00000011", r);
    else n_pass++;
    run_access(1'b0, 32'h2000, 4'h0, 32'h0, 1, "load_miss_2000", r);
    n_checks++;
    if (r !== 32'hCAFEF00D) $display("FAIL load_miss_2000 value: got %h, want cafef00d", r);
    else n_pass++;
  endtask

  task automatic test_ack_ignored();
    logic [31:0] r;
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.mem_req, bus.waiting} !== 2'b00)
      $display("FAIL ack_ignored ctrl: got req/waiting=%b, want 00", {bus.mem_req, bus.waiting});
    else n_pass++;
    @(negedge clk);
    run_access(1'b0, 32'h2000, 4'h0, 32'h0, 0, "ack_ignored_hit", r);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    run_access(1'b0, 32'h1230, 4'h0, 32'h0, int'($urandom_range(0, 3)), "b2b_miss_1230", r);
    run_access(1'b0, 32'h1234, 4'h0, 32'h0, 0, "b2b_hit_1234", r);
    run_access(1'b1, 32'h1238, 4'b1100, 32'h1357_9BDF, int'($urandom_range(0, 3)), "b2b_store_1238", r);
    run_access(1'b0, 32'h1238, 4'h0, 32'h0, 0, "b2b_hit_1238", r);
    run_access(1'b1, 32'h1234, 4'b0101, 32'hFFEE_DDCC, 0, "b2b_store_1234", r);
    run_access(1'b0, 32'h1234, 4'h0, 32'h0, 0, "b2b_hit_1234b", r);
    go_idle(1);
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] r;
    int acks;
    acks = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
    for (int cyc = 0; cyc < 50 && acks < 2; cyc++) begin
      #1;
      if (bus.mem_req) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem_rd(bus.mem_addr);
        acks++;
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (acks != 2 || bus.mem_req !== 1'b1)
      $display("FAIL mid_refill setup: got acks=%0d req=%b, want 2 and 1", acks, bus.mem_req);
    else n_pass++;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.waiting} !== 2'b00 || bus.mem_addr !== 32'h0)
      $display("FAIL mid_refill reset: got req/waiting=%b addr=%h, want 00 and 0",
               {bus.mem_req, bus.waiting}, bus.mem_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    run_access(1'b0, 32'h100, 4'h0, 32'h0, 1, "refill_after_reset", r);
    n_checks++;
    if (r !== 32'h11) $display("FAIL refill_after_reset value: got %h, want 00000011", r);
    else n_pass++;
    run_access(1'b0, 32'h2000, 4'h0, 32'h0, 0, "miss_after_reset_2000", r);
    go_idle(2);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    bus.cpu_wstrb = 4'h0; bus.cpu_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 24'h0;
    end
    mem_model[32'h100] = 32'h11;
    mem_model[32'h104] = 32'h22;
    mem_model[32'h108] = 32'h33;
    mem_model[32'h10C] = 32'h44;
    @(negedge clk);
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_conflict();
    test_store_miss();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the MEM stage and the external memory bus.
- Generates the `waiting` freeze signal consumed by every pipeline register: while `waiting` is high, all stages hold their contents.
- Refills 4-word lines using single-word memory transactions under a req/ack handshake.

Parameters:
- INDEX_W, 4, index width; LINES = 2^INDEX_W (16 lines).
- TAG_W, 32-INDEX_W-4, tag width (fixed by address split).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  MEM-stage load/store valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address, word-aligned
- cpu_wstrb  in  4  byte enables for stores
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_req & !cpu_we & !waiting
- waiting  out  1  pipeline freeze request
- mem_req  out  1  memory transaction request
- mem_we  out  1  memory write
- mem_addr  out  32  memory word address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Address split:
  - [1:0] byte offset
  - [3:2] word within line
  - [3+INDEX_W:4] index
  - [31:4+INDEX_W] tag
- Storage per line: valid bit, tag, 4 data words.
- Hit = valid[index] & tag match. Hit is computed combinationally from cpu_addr.
- States: IDLE, REFILL, WRITE, WDONE.
- IDLE:
  - Load hit: cpu_rdata = array word, waiting=0 in the same cycle (zero-latency hit).
  - Load miss: waiting=1 combinationally that cycle. Latch tag/index, clear word counter, go to REFILL.
  - Store (hit or miss): waiting=1. Latch addr/wdata/wstrb, go to WRITE.
  - Store hit: merge bytes per wstrb into the array word on the same edge.
  - Store miss: array is untouched.
  - cpu_req=0: waiting=0, stay in IDLE.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={latched tag, index, cnt, 2'b00}, mem_wstrb=4'b0000.
  - On each mem_ack: write mem_rdata into word cnt, cnt++.
  - On the ack with cnt==3: set valid, write tag, go to IDLE. The request then hits in IDLE, so waiting drops one cycle after the last ack.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=latched addr with [1:0]=0, mem_wdata/mem_wstrb=latched values.
  - On mem_ack: go to WDONE.
- WDONE:
  - waiting=0 for exactly one cycle so the pipeline advances past the store; next state IDLE.
- waiting = (state==REFILL) | (state==WRITE) | (state==IDLE & cpu_req & (cpu_we | !hit)).
- mem_req and mem_we are decoded from the state register only (glitch-free).
- mem_addr, mem_wdata and mem_wstrb are held stable while mem_req is high.
- mem_ack outside REFILL/WRITE is ignored.
- An ack arriving in the first cycle of a state is accepted.
- Reset values:
  - state=IDLE, cnt=0, all valid bits=0.
  - waiting=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, cpu_rdata=0 (while valid=0).
  - Data and tag arrays need no reset.
- Reset mid-refill: the line stays invalid, because valid is only set on the final ack. Partial data is harmless.
- Reset mid-write: the transaction is abandoned; mem_req drops asynchronously.
- Back-to-back accesses: the pipeline presents the next request the cycle after waiting=0. No internal queue.

Test Plan:
- Reset, then load 0x100 with memory returning 0x11,0x22,0x33,0x44 -> mem reads at 0x100,0x104,0x108,0x10C; waiting=1 until one cycle after the 4th ack; cpu_rdata=0x11.
- Then load 0x10C -> waiting=0 in the same cycle, cpu_rdata=0x44, mem_req stays 0.
- Store 0x108, wstrb=0011, wdata=0xAAAA5555 -> mem write at 0x108 with wstrb 0011; waiting high through ack, low in WDONE. Subsequent load 0x108 hits with 0x00005555 (line word was 0x33).
- Load 0x500 (same index 0, tag 5) -> miss, refill replaces the line. Following load 0x100 misses and refills again.
- Store miss 0x2000 -> single mem write, no array update. Load 0x2000 -> miss and refill.
- Assert rst after 2 refill acks for 0x100 -> mem_req=0, waiting=0 immediately. Load 0x100 after release -> full 4-word refill again.
